// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

    localparam int MEM_LAT_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/mem_arbiter_slot.sv
// Per-requester slot: holding register, pend flag (set wins over clear), rdata register.
module arb_req_slot #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_strobe,
    input  logic          i_rw,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_done,
    input  logic          i_load_rdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_pend,
    output logic          o_rw,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_wdata,
    output logic [DW-1:0] o_rdata
);

    logic          r_pend;
    logic          r_rw;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;

    // Request capture, completion clear and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend  <= 1'b0;
            r_rw    <= 1'b0;
            r_addr  <= {AW{1'b0}};
            r_wdata <= {DW{1'b0}};
            r_rdata <= {DW{1'b0}};
        end else begin
            // A new strobe is only accepted when free or in its own DONE cycle.
            if (i_strobe && (!r_pend || i_done)) begin
                r_pend  <= 1'b1;
                r_rw    <= i_rw;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end else if (i_done) begin
                r_pend  <= 1'b0;
            end else begin
                r_pend  <= r_pend;
            end
            if (i_load_rdata && !r_rw) begin
                r_rdata <= i_mem_rdata;
            end else begin
                r_rdata <= r_rdata;
            end
        end
    end

    assign o_pend  = r_pend;
    assign o_rw    = r_rw;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;
    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester main-memory arbiter with fixed-latency access timing.
// Build option: ARB_FIXED_PRIO_EN selects fixed priority (requester 1 wins ties).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int MEM_LAT = MEM_LAT_DEFAULT,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_strobe,
    input  logic          req0_rw,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_rdy,
    output logic [DW-1:0] req0_rdata,
    input  logic          req1_strobe,
    input  logic          req1_rw,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_rdy,
    output logic [DW-1:0] req1_rdata,
    output logic          mem_strobe,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    grant,
    output logic          busy
);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    req_id_t       r_owner;
    req_id_t       w_owner_nxt;
    logic [CW-1:0] r_cnt;
`ifndef ARB_FIXED_PRIO_EN
    req_id_t       r_last_grant;
`endif

    logic          w_pend0, w_pend1;
    logic          w_rw0, w_rw1;
    logic [AW-1:0] w_addr0, w_addr1;
    logic [DW-1:0] w_wdata0, w_wdata1;
    logic          w_done0, w_done1;
    logic          w_load, w_active;

    assign w_load   = (r_state == WAIT) && (r_cnt == CW'(1'b1));
    assign w_active = (r_state == ISSUE) || (r_state == WAIT);
    assign w_done0  = (r_state == DONE) && (r_owner == 1'b0);
    assign w_done1  = (r_state == DONE) && (r_owner == 1'b1);

    arb_req_slot #(.AW(AW), .DW(DW)) u_slot0 (
        .clk(clk), .reset(reset),
        .i_strobe(req0_strobe), .i_rw(req0_rw), .i_addr(req0_addr), .i_wdata(req0_wdata),
        .i_done(w_done0), .i_load_rdata(w_load && (r_owner == 1'b0)), .i_mem_rdata(mem_rdata),
        .o_pend(w_pend0), .o_rw(w_rw0), .o_addr(w_addr0), .o_wdata(w_wdata0), .o_rdata(req0_rdata)
    );

    arb_req_slot #(.AW(AW), .DW(DW)) u_slot1 (
        .clk(clk), .reset(reset),
        .i_strobe(req1_strobe), .i_rw(req1_rw), .i_addr(req1_addr), .i_wdata(req1_wdata),
        .i_done(w_done1), .i_load_rdata(w_load && (r_owner == 1'b1)), .i_mem_rdata(mem_rdata),
        .o_pend(w_pend1), .o_rw(w_rw1), .o_addr(w_addr1), .o_wdata(w_wdata1), .o_rdata(req1_rdata)
    );

    // Next-state and owner selection.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            IDLE: begin
                if (w_pend0 && w_pend1) begin
                    w_state_nxt = ISSUE;
`ifdef ARB_FIXED_PRIO_EN
                    w_owner_nxt = 1'b1;
`else
                    w_owner_nxt = ~r_last_grant;
`endif
                end else if (w_pend0 || w_pend1) begin
                    w_state_nxt = ISSUE;
                    w_owner_nxt = w_pend1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ISSUE: w_state_nxt = WAIT;
            WAIT: begin
                if (r_cnt == CW'(1'b1)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, owner, round-robin history and latency counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_cnt        <= {CW{1'b0}};
`ifndef ARB_FIXED_PRIO_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
`ifndef ARB_FIXED_PRIO_EN
            if ((r_state == IDLE) && (w_state_nxt == ISSUE)) begin
                r_last_grant <= w_owner_nxt;
            end else begin
                r_last_grant <= r_last_grant;
            end
`endif
            if (r_state == ISSUE) begin
                r_cnt <= CW'(MEM_LAT);
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - CW'(1'b1);
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Output decode from registered state; access fields are zero outside ISSUE/WAIT.
    always_comb begin
        mem_strobe = (r_state == ISSUE);
        busy       = (r_state != IDLE);
        req0_rdy   = w_done0;
        req1_rdy   = w_done1;
        mem_rw     = 1'b0;
        mem_addr   = {AW{1'b0}};
        mem_wdata  = {DW{1'b0}};
        grant      = 2'b00;
        if (w_active) begin
            mem_rw    = r_owner ? w_rw1    : w_rw0;
            mem_addr  = r_owner ? w_addr1  : w_addr0;
            mem_wdata = r_owner ? w_wdata1 : w_wdata0;
        end else begin
            mem_rw    = 1'b0;
        end
        if (r_state != IDLE) begin
            grant = r_owner ? 2'b10 : 2'b01;
        end else begin
            grant = 2'b00;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default round-robin build, MEM_LAT=4).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_strobe, req0_rw, req1_strobe, req1_rw;
    logic [15:0] req0_addr, req1_addr;
    logic [31:0] req0_wdata, req1_wdata, req0_rdata, req1_rdata;
    logic        req0_rdy, req1_rdy;
    logic        mem_strobe, mem_rw, busy;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [1:0]  grant;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.AW(16), .DW(32), .MEM_LAT(4), .CW(4)) dut (
        .clk(clk), .reset(reset),
        .req0_strobe(req0_strobe), .req0_rw(req0_rw), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_rdy(req0_rdy), .req0_rdata(req0_rdata),
        .req1_strobe(req1_strobe), .req1_rw(req1_rw), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_rdy(req1_rdy), .req1_rdata(req1_rdata),
        .mem_strobe(mem_strobe), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_strobe = 1'b0; req0_rw = 1'b0; req0_addr = 16'h0000; req0_wdata = 32'h0;
        req1_strobe = 1'b0; req1_rw = 1'b0; req1_addr = 16'h0000; req1_wdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        mem_rdata = 32'h0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("rst mem_strobe", {63'd0, mem_strobe}, 64'd0);
        check_val("rst grant", {62'd0, grant}, 64'd0);
        check_val("rst busy", {63'd0, busy}, 64'd0);
        check_val("rst rdy", {62'd0, req1_rdy, req0_rdy}, 64'd0);
        check_val("rst rdata0", {32'd0, req0_rdata}, 64'd0);
        check_val("rst mem_addr", {48'd0, mem_addr}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Lone read from requester 0: ISSUE at k2, rdy at k7.
    task automatic single_rd(input logic [31:0] d);
        for (int k = 0; k < 10; k++) begin
            idle_inputs();
            if (k == 0) begin req0_strobe = 1'b1; req0_addr = 16'h0040; end
            mem_rdata = d;
            @(negedge clk);
            check_val($sformatf("sr mem_strobe k%0d", k), {63'd0, mem_strobe}, {63'd0, (k == 2)});
            check_val($sformatf("sr grant k%0d", k), {62'd0, grant}, (k >= 2 && k <= 7) ? 64'd1 : 64'd0);
            check_val($sformatf("sr rdy0 k%0d", k), {63'd0, req0_rdy}, {63'd0, (k == 7)});
            if (k == 2) begin
                check_val("sr mem_addr", {48'd0, mem_addr}, 64'h0040);
                check_val("sr mem_rw", {63'd0, mem_rw}, 64'd0);
            end
            if (k == 7) check_val("sr rdata0", {32'd0, req0_rdata}, {32'd0, d});
            next_cycle();
        end
    endtask

    // Both strobe at k0; 'first' is the requester expected to be served first.
    task automatic both_case(input logic first, input logic [31:0] d1, input logic [31:0] d2);
        for (int k = 0; k < 17; k++) begin
            idle_inputs();
            if (k == 0) begin
                req0_strobe = 1'b1; req0_addr = 16'h0040;
                req1_strobe = 1'b1; req1_addr = 16'h0080;
            end
            mem_rdata = (k < 8) ? d1 : d2;
            @(negedge clk);
            check_val($sformatf("bc mem_strobe k%0d", k), {63'd0, mem_strobe}, {63'd0, (k == 2 || k == 9)});
            check_val($sformatf("bc rdy0 k%0d", k), {63'd0, req0_rdy}, {63'd0, (k == (first ? 14 : 7))});
            check_val($sformatf("bc rdy1 k%0d", k), {63'd0, req1_rdy}, {63'd0, (k == (first ? 7 : 14))});
            if (k >= 2 && k <= 7)
                check_val($sformatf("bc grant k%0d", k), {62'd0, grant}, first ? 64'd2 : 64'd1);
            else if (k >= 9 && k <= 14)
                check_val($sformatf("bc grant k%0d", k), {62'd0, grant}, first ? 64'd1 : 64'd2);
            else
                check_val($sformatf("bc grant k%0d", k), {62'd0, grant}, 64'd0);
            if (k == 2) check_val("bc addr first", {48'd0, mem_addr}, first ? 64'h0080 : 64'h0040);
            if (k == 9) check_val("bc addr second", {48'd0, mem_addr}, first ? 64'h0040 : 64'h0080);
            if (k == 14) begin
                check_val("bc rdata0", {32'd0, req0_rdata}, {32'd0, (first ? d2 : d1)});
                check_val("bc rdata1", {32'd0, req1_rdata}, {32'd0, (first ? d1 : d2)});
            end
            next_cycle();
        end
    endtask

    initial begin
        do_reset();
        single_rd(32'hDEADBEEF);

        do_reset();
        both_case(1'b0, 32'h11111111, 32'h22222222);
        both_case(1'b0, 32'h33333333, 32'h44444444);
        single_rd(32'h55555555);
        both_case(1'b1, 32'h66666666, 32'h77777777);

        // Write from requester 1: rdata1 keeps 0x66666666 from the previous read.
        for (int k = 0; k < 10; k++) begin
            idle_inputs();
            if (k == 0) begin
                req1_strobe = 1'b1; req1_rw = 1'b1; req1_addr = 16'h0100; req1_wdata = 32'h12345678;
            end
            mem_rdata = 32'hBADBAD00;
            @(negedge clk);
            check_val($sformatf("wr mem_rw k%0d", k), {63'd0, mem_rw}, {63'd0, (k >= 2 && k <= 6)});
            check_val($sformatf("wr rdy1 k%0d", k), {63'd0, req1_rdy}, {63'd0, (k == 7)});
            if (k >= 2 && k <= 6) begin
                check_val($sformatf("wr wdata k%0d", k), {32'd0, mem_wdata}, 64'h12345678);
                check_val($sformatf("wr addr k%0d", k), {48'd0, mem_addr}, 64'h0100);
            end
            if (k == 7) begin
                check_val("wr grant", {62'd0, grant}, 64'd2);
                check_val("wr rdata1", {32'd0, req1_rdata}, 64'h66666666);
            end
            next_cycle();
        end

        // Back-to-back from requester 0; the k3 strobe is ignored while pending.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            idle_inputs();
            if (k == 0) begin req0_strobe = 1'b1; req0_addr = 16'h0040; end
            if (k == 3) begin req0_strobe = 1'b1; req0_addr = 16'h0099; end
            if (k == 7) begin req0_strobe = 1'b1; req0_addr = 16'h0044; end
            mem_rdata = 32'hA5A5A5A5;
            @(negedge clk);
            check_val($sformatf("bb mem_strobe k%0d", k), {63'd0, mem_strobe}, {63'd0, (k == 2 || k == 9)});
            check_val($sformatf("bb rdy0 k%0d", k), {63'd0, req0_rdy}, {63'd0, (k == 7 || k == 14)});
            if (k == 4) check_val("bb addr hold", {48'd0, mem_addr}, 64'h0040);
            if (k == 9) check_val("bb addr 2nd", {48'd0, mem_addr}, 64'h0044);
            next_cycle();
        end

        // Reset in WAIT at k4: IDLE at k5, never a rdy, no reissue.
        do_reset();
        for (int k = 0; k < 14; k++) begin
            idle_inputs();
            if (k == 0) begin req0_strobe = 1'b1; req0_addr = 16'h0040; end
            reset = (k == 4);
            mem_rdata = 32'hDEADBEEF;
            @(negedge clk);
            check_val($sformatf("rw rdy0 k%0d", k), {63'd0, req0_rdy}, 64'd0);
            if (k == 3) check_val("rw busy in wait", {63'd0, busy}, 64'd1);
            if (k >= 5) begin
                check_val($sformatf("rw busy k%0d", k), {63'd0, busy}, 64'd0);
                check_val($sformatf("rw grant k%0d", k), {62'd0, grant}, 64'd0);
            end
            next_cycle();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
